// File: rtl/reg5_serial_tx_if.sv
// Parallel-load / serial-line bundle for reg5_serial_tx.
//   Load   : request to send inData (taken only while Ready=1)
//   inData : DATA_W-bit word to frame and send
//   Ready  : transmitter idle, can accept Load
//   TxOut  : serial line, idles high
//   Done   : one-cycle pulse at frame completion
// master = word source (datapath side), slave = transmitter.
interface reg5_serial_tx_if #(
    parameter int DATA_W = 5
);
    logic              Load;
    logic [DATA_W-1:0] inData;
    logic              Ready;
    logic              TxOut;
    logic              Done;

    modport master (output Load, output inData, input Ready, input TxOut, input Done);
    modport slave  (input Load, input inData, output Ready, output TxOut, output Done);
endinterface

// File: rtl/reg5_serial_tx.sv
// Framed serial transmitter for datapath words.
// Sends start bit (0), DATA_W data bits, stop bit (1); each line bit is held
// for CLKS_PER_BIT clocks. LSB_FIRST picks the data bit order.
// Ports:
//   Clock : system clock, rising edge
//   Clear : synchronous active-high reset, overrides everything
//   bus   : slave side of reg5_serial_tx_if (Load/inData in, Ready/TxOut/Done out)
// All outputs are registered.
module reg5_serial_tx #(
    parameter int DATA_W       = 5,
    parameter int CLKS_PER_BIT = 4,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Clear,
    reg5_serial_tx_if.slave      bus
);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateType;

    stateType          state;
    logic [DATA_W-1:0] shiftReg;
    logic [CNT_W-1:0]  bitCnt;
    logic [DIV_W-1:0]  divCnt;
    logic              txReg;
    logic              readyReg;
    logic              doneReg;

    // Next data bit to drive and the register after it has been consumed.
    logic              headBit;
    logic [DATA_W-1:0] shiftNext;

    always_comb begin
        headBit   = LSB_FIRST ? shiftReg[0] : shiftReg[DATA_W-1];
        shiftNext = LSB_FIRST ? (shiftReg >> 1) : (shiftReg << 1);
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state    <= IDLE;
            txReg    <= 1'b1;
            readyReg <= 1'b1;
            doneReg  <= 1'b0;
            shiftReg <= '0;
            bitCnt   <= '0;
            divCnt   <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    txReg <= 1'b1;
                    if (bus.Load) begin
                        shiftReg <= bus.inData;
                        state    <= START;
                        txReg    <= 1'b0;
                        readyReg <= 1'b0;
                        divCnt   <= '0;
                    end
                end
                START: begin
                    if (divCnt == DIV_LAST) begin
                        divCnt   <= '0;
                        bitCnt   <= '0;
                        state    <= DATA;
                        txReg    <= headBit;
                        shiftReg <= shiftNext;
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (divCnt == DIV_LAST) begin
                        divCnt <= '0;
                        if (bitCnt == CNT_LAST) begin
                            state <= STOP;
                            txReg <= 1'b1;
                        end else begin
                            bitCnt   <= bitCnt + 1'b1;
                            txReg    <= headBit;
                            shiftReg <= shiftNext;
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (divCnt == DIV_LAST) begin
                        divCnt   <= '0;
                        state    <= IDLE;
                        readyReg <= 1'b1;
                        doneReg  <= 1'b1;
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    txReg    <= 1'b1;
                    readyReg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.TxOut = txReg;
    assign bus.Ready = readyReg;
    assign bus.Done  = doneReg;
endmodule

// File: tb/tb_reg5_serial_tx.sv
module tb_reg5_serial_tx;
    logic clk = 1'b0;
    logic clr0, clr1;
    always #5 clk = ~clk;

    reg5_serial_tx_if #(.DATA_W(5)) bus0 ();
    reg5_serial_tx_if #(.DATA_W(5)) bus1 ();

    reg5_serial_tx #(.DATA_W(5), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut0 (
        .Clock(clk), .Clear(clr0), .bus(bus0));
    reg5_serial_tx #(.DATA_W(5), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0)) dut1 (
        .Clock(clk), .Clear(clr1), .bus(bus1));

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is the list of per-cycle line samples: start, data, stop,
    // each repeated cpb times. Ready is low exactly while samples are shown.
    localparam int W = 5;
    int          cpbOf[2] = '{4, 1};
    bit          lsbOf[2] = '{1'b1, 1'b0};
    logic [63:0] mS[2];
    int          mN[2], mPos[2];
    logic        mTx[2], mReady[2], mDone[2];
    bit          mValid[2] = '{1'b0, 1'b0};

    function automatic logic [63:0] expand(input logic [W-1:0] d, input bit lsb, input int cpb);
        logic [63:0] s = '0;
        for (int i = 0; i < (W + 2) * cpb; i++) begin
            int b = i / cpb;
            if (b == 0)          s[i] = 1'b0;
            else if (b == W + 1) s[i] = 1'b1;
            else                 s[i] = lsb ? d[b-1] : d[W-b];
        end
        return s;
    endfunction

    task automatic modelStep(input int k, input logic clr, input logic ld, input logic [W-1:0] d);
        if (clr) begin
            mN[k] = 0; mPos[k] = 0;
            mTx[k] = 1'b1; mReady[k] = 1'b1; mDone[k] = 1'b0; mValid[k] = 1'b1;
        end else if (!mValid[k]) begin
            // outputs undefined until the first Clear
        end else if (mReady[k] && ld) begin
            mS[k] = expand(d, lsbOf[k], cpbOf[k]);
            mN[k] = (W + 2) * cpbOf[k];
            mTx[k] = mS[k][0]; mPos[k] = 1;
            mReady[k] = 1'b0; mDone[k] = 1'b0;
        end else if (!mReady[k]) begin
            if (mPos[k] < mN[k]) begin
                mTx[k] = mS[k][mPos[k]]; mPos[k]++; mDone[k] = 1'b0;
            end else begin
                mTx[k] = 1'b1; mReady[k] = 1'b1; mDone[k] = 1'b1;
            end
        end else begin
            mTx[k] = 1'b1; mDone[k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        modelStep(0, clr0, bus0.Load, bus0.inData);
        modelStep(1, clr1, bus1.Load, bus1.inData);
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mValid[0]) begin
            chk("dut0.TxOut", 32'(bus0.TxOut), 32'(mTx[0]));
            chk("dut0.Ready", 32'(bus0.Ready), 32'(mReady[0]));
            chk("dut0.Done",  32'(bus0.Done),  32'(mDone[0]));
        end
        if (mValid[1]) begin
            chk("dut1.TxOut", 32'(bus1.TxOut), 32'(mTx[1]));
            chk("dut1.Ready", 32'(bus1.Ready), 32'(mReady[1]));
            chk("dut1.Done",  32'(bus1.Done),  32'(mDone[1]));
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    function automatic logic getTx(input int k);
        return (k == 0) ? bus0.TxOut : bus1.TxOut;
    endfunction
    function automatic logic getReady(input int k);
        return (k == 0) ? bus0.Ready : bus1.Ready;
    endfunction
    function automatic logic getDone(input int k);
        return (k == 0) ? bus0.Done : bus1.Done;
    endfunction
    task automatic setIn(input int k, input logic ld, input logic [W-1:0] d);
        if (k == 0) begin bus0.Load = ld; bus0.inData = d; end
        else        begin bus1.Load = ld; bus1.inData = d; end
    endtask

    // Called at a negedge; the accept happens on the following posedge.
    // expBits[6] is the first line bit (start), expBits[0] the stop bit.
    task automatic runFrame(input int k, input logic [W-1:0] d, input logic [6:0] expBits,
                            input int midCyc, input bit keepLoad, input string nm);
        int cpb = cpbOf[k];
        logic [6:0] got = '0;
        int lowCnt = 0, doneCnt = 0;
        setIn(k, 1'b1, d);
        for (int c = 0; c < 7 * cpb; c++) begin
            @(negedge clk);
            if (c == 0 && !keepLoad) setIn(k, 1'b0, d);
            if (c == midCyc)     setIn(k, 1'b1, 5'd31);
            if (c == midCyc + 1) setIn(k, 1'b0, 5'd31);
            if (c % cpb == 0) got[6 - c / cpb] = getTx(k);
            if (!getReady(k)) lowCnt++;
            if (getDone(k))   doneCnt++;
        end
        @(negedge clk);
        chk({nm, ".bits"},    32'(got), 32'(expBits));
        chk({nm, ".readyLow"}, 32'(lowCnt), 32'(7 * cpb));
        chk({nm, ".earlyDone"}, 32'(doneCnt), 32'd0);
        chk({nm, ".done"},    32'(getDone(k)), 32'd1);
        chk({nm, ".readyUp"}, 32'(getReady(k)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        clr0 = 1'b1; clr1 = 1'b1;
        setIn(0, 1'b0, '0); setIn(1, 1'b0, '0);
        repeat (2) @(negedge clk);
        clr0 = 1'b0; clr1 = 1'b0;
        // idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle.TxOut", 32'(bus0.TxOut), 32'd1);
            chk("idle.Ready", 32'(bus0.Ready), 32'd1);
            chk("idle.Done",  32'(bus0.Done),  32'd0);
        end

        // 5'd7, LSB first, 4 clocks per bit
        runFrame(0, 5'd7, 7'b0111001, -10, 1'b0, "send7");
        repeat (3) @(negedge clk);

        // MSB first, 1 clock per bit
        runFrame(1, 5'd6, 7'b0001101, -10, 1'b0, "msb6");
        repeat (3) @(negedge clk);

        // Load mid-frame ignored
        runFrame(0, 5'd10, 7'b0010101, 8, 1'b0, "ignore31");
        repeat (6) @(negedge clk);
        chk("ignore31.idleAfter", 32'(bus0.Ready), 32'd1);

        // Clear mid-frame
        setIn(0, 1'b1, 5'd21);
        @(negedge clk);
        setIn(0, 1'b0, 5'd21);
        repeat (11) @(negedge clk);
        chk("abort.lineLow", 32'(bus0.Ready), 32'd0);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("abort.TxOut", 32'(bus0.TxOut), 32'd1);
        chk("abort.Ready", 32'(bus0.Ready), 32'd1);
        chk("abort.Done",  32'(bus0.Done),  32'd0);
        repeat (4) @(negedge clk);
        runFrame(0, 5'd3, 7'b0110001, -10, 1'b0, "after3");
        repeat (3) @(negedge clk);

        // back-to-back frames, then Clear+Load together
        runFrame(0, 5'd5, 7'b0101001, -10, 1'b1, "b2b5");
        runFrame(0, 5'd18, 7'b0010011, -10, 1'b1, "b2b18");
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        setIn(0, 1'b0, 5'd18);
        chk("clrLoad.TxOut", 32'(bus0.TxOut), 32'd1);
        chk("clrLoad.Ready", 32'(bus0.Ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("clrLoad.idle", 32'(bus0.TxOut), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
